bsg_upstream_ch: RTL

Upstream (transmit) channel of the off-chip link: accepts 32-bit words from the core over a valid/ready handshake and buffers them in a small FIFO. It serializes each word into four 8-bit beats on the I/O side and paces transmission with a credit counter replenished by token pulses from the far-end downstream channel. It pairs with the downstream receiver, which reassembles beats into core words and returns one token per word it frees.

---
 rtl/bsg_up_pkg.sv | 20 ++
 rtl/bsg_upstream_ch_if.sv | 28 ++
 rtl/bsg_up_fifo.sv | 59 +++++
 rtl/bsg_upstream_ch.sv | 135 +++++++++++++
 4 files changed

// File: rtl/bsg_up_pkg.sv
// Shared constants, state encoding and sizing helpers for the upstream link channel.
package bsg_up_pkg;

    localparam int unsigned CORE_W_DEF = 32'd32;
    localparam int unsigned IO_W_DEF   = 32'd8;
    localparam int unsigned BEATS      = CORE_W_DEF / IO_W_DEF;

    // A single-beat word still needs a one-bit counter to stay a legal vector.
    function automatic int unsigned beat_cnt_w(input int unsigned beats);
        return (beats > 32'd1) ? $clog2(beats) : 32'd1;
    endfunction

    localparam int unsigned BEAT_W = beat_cnt_w(BEATS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } up_state_e;

endpackage

// File: rtl/bsg_upstream_ch_if.sv
// Core-side handshake, I/O-side beat/token and credit debug signals of the upstream channel.
interface bsg_upstream_ch_if
    import bsg_up_pkg::*;
#(
    parameter int unsigned CORE_W  = CORE_W_DEF,
    parameter int unsigned IO_W    = IO_W_DEF,
    parameter int unsigned CREDITS = 32'd32
);

    logic [CORE_W-1:0]              core_data_in;
    logic                           core_valid_in;
    logic                           core_ready_out;
    logic [IO_W-1:0]                io_data_out;
    logic                           io_valid_out;
    logic                           io_token_in;
    logic [$clog2(CREDITS+1)-1:0]   credit_cnt;

    modport master (
        output core_data_in, core_valid_in, io_token_in,
        input  core_ready_out, io_data_out, io_valid_out, credit_cnt
    );

    modport slave (
        input  core_data_in, core_valid_in, io_token_in,
        output core_ready_out, io_data_out, io_valid_out, credit_cnt
    );

endinterface

// File: rtl/bsg_up_fifo.sv
// Synchronous word FIFO; pointers carry one wrap bit so full and empty are distinguishable.
module bsg_up_fifo
    import bsg_up_pkg::*;
#(
    parameter int unsigned WIDTH = CORE_W_DEF,
    parameter int unsigned DEPTH = 32'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_s;
    logic             pop_s;

    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    // Storage array; data needs no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    assign dout  = mem_r[rd_ptr_r[AW-1:0]];
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

endmodule

// File: rtl/bsg_upstream_ch.sv
// Upstream link channel: buffers core words, serializes them LSB-first into I/O beats
// and paces whole words with a token-replenished credit counter.
module bsg_upstream_ch
    import bsg_up_pkg::*;
#(
    parameter int unsigned CORE_W     = CORE_W_DEF,
    parameter int unsigned IO_W       = IO_W_DEF,
    parameter int unsigned FIFO_DEPTH = 32'd4,
    parameter int unsigned CREDITS    = 32'd32
) (
    input  logic                clk,
    input  logic                rst,
    bsg_upstream_ch_if.slave    ch
);

    localparam int unsigned NBEATS = CORE_W / IO_W;
    localparam int unsigned BCNT_W = beat_cnt_w(NBEATS);
    localparam int unsigned CRED_W = $clog2(CREDITS + 1);

    up_state_e          state_r;
    up_state_e          state_s;
    logic [CORE_W-1:0]  shift_r;
    logic [BCNT_W-1:0]  beat_r;
    logic [IO_W-1:0]    io_data_r;
    logic               io_valid_r;
    logic [CRED_W-1:0]  credit_r;

    logic [CORE_W-1:0]  fifo_dout_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               push_s;
    logic               start_s;
    logic               can_start_s;
    logic               last_beat_s;

    bsg_up_fifo #(
        .WIDTH (CORE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (ch.core_data_in),
        .pop   (start_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign ch.core_ready_out = !fifo_full_s && !rst;
    assign push_s            = ch.core_valid_in && ch.core_ready_out;

    // A same-cycle token counts as a credit, so a drained counter restarts without a bubble.
    assign can_start_s = !fifo_empty_s && ((credit_r != {CRED_W{1'b0}}) || ch.io_token_in);
    assign last_beat_s = (beat_r == BCNT_W'(NBEATS - 1));

    // Next-state logic; credits are only consulted at word boundaries.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (can_start_s) begin
                    start_s = 1'b1;
                    state_s = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (!last_beat_s) begin
                    state_s = SEND;
                end else if (can_start_s) begin
                    start_s = 1'b1;
                    state_s = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register, shift register and registered beat outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            shift_r    <= {CORE_W{1'b0}};
            beat_r     <= {BCNT_W{1'b0}};
            io_data_r  <= {IO_W{1'b0}};
            io_valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (start_s) begin
                io_data_r  <= fifo_dout_s[IO_W-1:0];
                shift_r    <= fifo_dout_s >> IO_W;
                beat_r     <= {BCNT_W{1'b0}};
                io_valid_r <= 1'b1;
            end else if ((state_r == SEND) && !last_beat_s) begin
                io_data_r  <= shift_r[IO_W-1:0];
                shift_r    <= shift_r >> IO_W;
                beat_r     <= beat_r + BCNT_W'(1);
                io_valid_r <= 1'b1;
            end else begin
                io_valid_r <= 1'b0;
            end
        end
    end

    // Credit counter: start and token together cancel; a lone token saturates at CREDITS.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_r <= CRED_W'(CREDITS);
        end else begin
            case ({start_s, ch.io_token_in})
                2'b10: credit_r <= credit_r - CRED_W'(1);
                2'b01: begin
                    if (credit_r != CRED_W'(CREDITS)) begin
                        credit_r <= credit_r + CRED_W'(1);
                    end else begin
                        credit_r <= credit_r;
                    end
                end
                default: credit_r <= credit_r;
            endcase
        end
    end

    assign ch.io_data_out  = io_data_r;
    assign ch.io_valid_out = io_valid_r;
    assign ch.credit_cnt   = credit_r;

endmodule
